apple2_ram_arbiter: RTL
=======================

// Module: apple2_ram_arbiter
// PURPOSE
//  Shares the single-port 48KB unified RAM (apple2_ram) between the CPU wrapper and the
//  text-mode video fetcher, one transaction at a time. Sits between both requesters and apple2_ram.
//  Video has fixed priority, with a starvation guard for the CPU. Writes above RAM_TOP are blocked.
// PARAMETERS
//  ADDR_W        16       address width, both requesters and RAM
//  DATA_W        8        data width
//  RAM_LAT       1        RAM read latency in cycles, from ram_addr valid to ram_rdata valid (>=1)
//  CPU_MAX_WAIT  4        consecutive video grants allowed while cpu_req is pending (>=1)
//  RAM_TOP       16'hC000 first address outside RAM; writes there are dropped, reads return all-ones
// PORTS
//  clk        in   1       pixel clock; the block's only clock
//  rst_n      in   1       synchronous, active-low reset
//  cpu_req    in   1       CPU transaction request; held, with addr/we/wdata stable, until cpu_ack
//  cpu_we     in   1       1=write, 0=read
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_ack    out  1       one-cycle pulse: transaction complete, cpu_rdata valid (reads)
//  cpu_rdata  out  DATA_W  registered read data; holds until the next CPU read completes
//  vid_req    in   1       video read request; held, with vid_addr stable, until vid_ack
//  vid_addr   in   ADDR_W  video read address
//  vid_ack    out  1       one-cycle pulse: vid_rdata valid
//  vid_rdata  out  DATA_W  registered video read data
//  ram_addr   out  ADDR_W  registered RAM address
//  ram_we     out  1       RAM write enable; high only in ISSUE for an in-range CPU write
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data
//  busy       out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE; all outputs 0; starvation counter=0.
//   An in-flight transaction is abandoned and never acknowledged.
//  FSM: IDLE -> ISSUE -> WAIT (RAM_LAT cycles) -> DONE -> IDLE.
//  IDLE: samples vid_req and cpu_req and picks the winner. If neither is high, stays in IDLE.
//   On a winner, registers ram_addr/ram_wdata/ram_we and moves to ISSUE.
//  Arbitration:
//   - Only vid_req high -> video wins.
//   - Only cpu_req high -> CPU wins.
//   - Both high -> video wins unless starve_cnt==CPU_MAX_WAIT, in which case CPU wins.
//  starve_cnt: +1 on each video grant while cpu_req=1; cleared on a CPU grant or when cpu_req=0
//   in IDLE; saturates at CPU_MAX_WAIT.
//  ISSUE: ram_addr/ram_we valid; ram_we=1 only for CPU writes with cpu_addr<RAM_TOP.
//   ram_we drops to 0 on leaving ISSUE.
//  WAIT: counts RAM_LAT cycles. On the last cycle, latches ram_rdata into the winner's rdata register.
//   Reads at addr>=RAM_TOP load all-ones instead. Writes leave rdata unchanged.
//  DONE: the winner's ack is high for exactly one cycle; the FSM then returns to IDLE.
//   Requests are not sampled in DONE. A requester that keeps req high after its ack is
//   treated as presenting a new request in the following IDLE.
//  Latency (request high in IDLE at cycle 0): ISSUE=1, WAIT=2..1+RAM_LAT, ack=2+RAM_LAT
//   (cycle 3 at RAM_LAT=1). Throughput: one transaction per 3+RAM_LAT cycles.
//  cpu_ack and vid_ack are never high in the same cycle. Exactly one ack per granted transaction.
//  Requests that drop before their ack are protocol violations. The granted transaction still
//   completes and is acknowledged.
//  Address compare is unsigned over the full ADDR_W.
// TESTING
//  1 CPU write 0x0400<-0x41, no video -> ram_we=1 only in cycle 1 with ram_addr=0x0400;
//    cpu_ack cycle 3. Then read 0x0400 -> cpu_rdata=0x41 with cpu_ack.
//  2 cpu_req and vid_req both rise in cycle 0, starve_cnt=0 -> vid_ack cycle 3, cpu_ack cycle 7,
//    ram_we=1 in cycle 5 only.
//  3 vid_req and cpu_req held high continuously, CPU_MAX_WAIT=4 -> 4 vid_acks, then 1 cpu_ack,
//    repeating. No ack overlap.
//  4 CPU write 0xC010 -> ram_we never 1, cpu_ack cycle 3. Read 0xD000 -> cpu_rdata=0xFF.
//  5 rst_n=0 for one cycle during ISSUE of a CPU write -> no ack; ram_we=0 and busy=0 the next cycle.
//    A new request after release is acked at +3.
//  6 RAM_LAT=2, video read 0x0428 with RAM preloaded 0xC1 -> vid_ack cycle 4, vid_rdata=0xC1.

Source files
------------

// File: rtl/apple2_ram_arbiter.sv
// apple2_ram_arbiter: shares the single-port unified RAM between the CPU wrapper and the video fetcher.
// Latency: request sampled in IDLE at cycle 0 -> ISSUE at 1, ack pulse at 2+RAM_LAT; one transaction per 3+RAM_LAT cycles.
// Backpressure: req/ack handshake; a requester holds req and operands until its ack, a losing requester simply waits.
//
// Ports:
//  clk, rst_n                               pixel clock, synchronous active-low reset
//  cpu_req/cpu_we/cpu_addr/cpu_wdata        CPU request (held until cpu_ack)
//  cpu_ack/cpu_rdata                        CPU completion pulse and registered read data
//  vid_req/vid_addr                         video read request (held until vid_ack)
//  vid_ack/vid_rdata                        video completion pulse and registered read data
//  ram_addr/ram_we/ram_wdata/ram_rdata      registered interface to the single-port RAM
//  busy                                     high whenever a transaction is in flight
module apple2_ram_arbiter #(
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       RAM_LAT      = 1,
  parameter int unsigned       CPU_MAX_WAIT = 4,
  parameter logic [ADDR_W-1:0] RAM_TOP      = 16'hC000
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU requester
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  // video requester (read only)
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int unsigned STARVE_W = $clog2(CPU_MAX_WAIT + 1);
  localparam int unsigned LAT_W    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(CPU_MAX_WAIT);
  localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(RAM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Everything the later states need to know about the granted transaction.
  typedef struct packed {
    logic is_cpu;  // 1: CPU owns this slot, 0: video
    logic we;      // CPU write
    logic oob;     // address at or above RAM_TOP
  } txn_t;

  state_e               state_q,     state_d;
  txn_t                 txn_q,       txn_d;
  logic [STARVE_W-1:0]  starve_q,    starve_d;
  logic [LAT_W-1:0]     lat_q,       lat_d;
  logic [ADDR_W-1:0]    ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0]    ram_wdata_q, ram_wdata_d;
  logic                 ram_we_q,    ram_we_d;
  logic [DATA_W-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]    vid_rdata_q, vid_rdata_d;
  logic                 cpu_ack_q,   cpu_ack_d;
  logic                 vid_ack_q,   vid_ack_d;

  logic                 cpu_oob;
  logic                 vid_oob;
  logic                 grant_vid;
  logic                 grant_cpu;
  logic [DATA_W-1:0]    rd_value;

  // Full-width unsigned compare; anything at or above RAM_TOP is outside the RAM.
  assign cpu_oob = (cpu_addr >= RAM_TOP);
  assign vid_oob = (vid_addr >= RAM_TOP);

  // Video has priority except when the CPU has already been passed over
  // CPU_MAX_WAIT times in a row while waiting.
  assign grant_vid = vid_req && !(cpu_req && (starve_q == STARVE_MAX));
  assign grant_cpu = cpu_req && !grant_vid;

  // Out-of-range reads bypass the RAM and return all-ones.
  assign rd_value = txn_q.oob ? {DATA_W{1'b1}} : ram_rdata;

  always_comb begin
    state_d     = state_q;
    txn_d       = txn_q;
    starve_d    = starve_q;
    lat_d       = lat_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_cpu) begin
          starve_d    = '0;
          txn_d       = '{is_cpu: 1'b1, we: cpu_we, oob: cpu_oob};
          ram_addr_d  = cpu_addr;
          ram_wdata_d = cpu_wdata;
          // Writes above the RAM are swallowed here; the CPU is still acked.
          ram_we_d    = cpu_we && !cpu_oob;
          state_d     = ST_ISSUE;
        end else begin
          if (!cpu_req) begin
            starve_d = '0;
          end else if (grant_vid && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + STARVE_W'(1);
          end
          if (grant_vid) begin
            txn_d      = '{is_cpu: 1'b0, we: 1'b0, oob: vid_oob};
            ram_addr_d = vid_addr;
            state_d    = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        lat_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (lat_q == LAT_LAST) begin
          // ram_rdata is valid on the final WAIT cycle; writes keep the old rdata.
          if (!txn_q.we) begin
            if (txn_q.is_cpu) begin
              cpu_rdata_d = rd_value;
            end else begin
              vid_rdata_d = rd_value;
            end
          end
          cpu_ack_d = txn_q.is_cpu;
          vid_ack_d = !txn_q.is_cpu;
          state_d   = ST_DONE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      ST_DONE: begin
        // Requests are deliberately not looked at here; a held req is
        // picked up as a fresh request in the next IDLE cycle.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      txn_q       <= '0;
      starve_q    <= '0;
      lat_q       <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      txn_q       <= txn_d;
      starve_q    <= starve_d;
      lat_q       <= lat_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_ack   = vid_ack_q;
  assign vid_rdata = vid_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
